timestamp_capture: RTL and testbench
====================================

// Module: timestamp_capture
// PURPOSE
//  Downstream consumer of the free-running 32-bit HPS timer count. Detects rising edges on
//  NUM_CH asynchronous event inputs (encoder index, sensor pulses) and stamps each edge with
//  the current timer value. Queues {channel, timestamp} records in a FIFO. The HPS drains
//  the FIFO over an Avalon-MM slave (read latency 1).
// PARAMETERS
//  NUM_CH      4   number of event inputs, 1..8
//  FIFO_DEPTH  16  FIFO entries, power of 2, 2..256
// PORTS
//  clk            in   1       system clock (same domain as timer)
//  reset          in   1       synchronous, active-high
//  timer          in   32      free-running timestamp count
//  event_in       in   NUM_CH  asynchronous event inputs
//  avs_address    in   2       register select
//  avs_read       in   1       read strobe, one cycle per access
//  avs_write      in   1       write strobe
//  avs_writedata  in   32      write data
//  avs_readdata   out  32      read data, registered, valid cycle after avs_read
//  irq            out  1       high while FIFO non-empty and irq_en=1
// BEHAVIOUR
//  Reset: sync regs, pending, capture regs, FIFO pointers, overflow, readdata = 0;
//   enable mask = all ones; irq_en = 0; irq = 0.
//  Input path per channel:
//   - 2-FF synchroniser, then rising-edge detect (sync2 & ~sync2_d).
//   - Edge detect is gated by enable[ch].
//  Capture:
//   - On a detect cycle, if pending[ch]=0: cap[ch] <= timer (value in that cycle), pending[ch] <= 1.
//   - If pending[ch]=1: the edge is dropped, cap[ch] is unchanged, overflow <= 1.
//  Arbiter:
//   - Each cycle, the lowest-index pending channel is pushed if the FIFO can accept.
//   - Push record = {ch[2:0], cap[ch]}; pending[ch] clears on the same edge.
//   - One push per cycle. Other pending channels wait; no data is lost while pending.
//  Latency: a raw input high at edge k is detected at edge k+2. If not blocked, it is pushed at
//   edge k+3 and visible in COUNT on the following read.
//  FIFO can accept if not full, or if a pop occurs in the same cycle.
//   - Full with no pop: entries stay pending.
//   - Simultaneous push and pop: COUNT is unchanged.
//  Pointer/count arithmetic: pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. COUNT is
//   log2(FIFO_DEPTH)+1 bits.
//  Register map (readdata updates only on avs_read; other cycles hold):
//   - 0 STATUS (RO): [0] empty, [1] full, [2] overflow, [16+:9] count.
//   - 1 TSTAMP (RO, pop): head timestamp. The read pops the head. Read of an empty FIFO
//     returns 0 and does not pop.
//   - 2 HEADCH (RO): [2:0] head channel, no pop. Returns 0 when empty. Read before TSTAMP.
//   - 3 CTRL (RW): [7:0] enable mask, [8] irq_en, [31] write-1 clears overflow (self-clearing,
//     reads 0). Read returns current mask/irq_en.
//  Writes to addresses 0..2 are ignored. Disabling a channel does not clear its pending entry.
//  If an overflow set and a write-1-clear occur in the same cycle, the set wins.
//  Reset mid-operation flushes the FIFO and pending entries. The first edge after reset is not
//   detected until sync regs see 0 then 1.
//  The timer wrap (0xFFFFFFFF -> 0) is captured verbatim; there is no extension.
// TESTING
//  - Single event: timer=100+cycle, pulse event_in[1] -> HEADCH=1, TSTAMP=timer at detect,
//    COUNT 1->0.
//  - Simultaneous: rise ch0 and ch2 in the same cycle -> two entries, ch0 first then ch2, both
//    with the identical timestamp.
//  - Full: 17 events with FIFO_DEPTH=16 and no reads -> full=1, 17th stays pending. After one
//    pop it enters, count=16.
//  - Overflow: two edges on ch3 while its entry is blocked -> overflow=1, one record retained.
//    CTRL[31]=1 -> overflow=0.
//  - Empty read: TSTAMP read on empty -> 0, count stays 0. Mask ch0 off -> edges ignored.
//  - Reset mid-stream with 5 queued -> STATUS=0x1 (empty), irq=0, CTRL reads 0xFF.

Source files
------------

// File: rtl/timestamp_capture.sv
// rtl/timestamp_capture.sv - timestamps rising edges on async event inputs into a FIFO drained over Avalon-MM
module timestamp_capture #(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       timer,
    input  logic [NUM_CH-1:0] event_in,
    input  logic [1:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              irq
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [NUM_CH-1:0] sync1_q, sync2_q, sync3_q;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [31:0]       cap_q [NUM_CH];
    logic [31:0]       cap_d [NUM_CH];
    logic [34:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        en_q, en_d;
    logic              irq_en_q, irq_en_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [NUM_CH-1:0] detect, push_oh;
    logic              empty, full, pop, push, push_valid, ovf_set, ctrl_wr;
    logic [2:0]        push_ch;
    logic [31:0]       push_ts;
    logic [34:0]       head;
    logic              unused_wdata;

    assign unused_wdata = ^avs_writedata[30:9];

    assign detect  = sync2_q & ~sync3_q & en_q[NUM_CH-1:0];
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = avs_read && (avs_address == 2'd1) && !empty;
    assign push    = push_valid && (!full || pop);
    assign ctrl_wr = avs_write && (avs_address == 2'd3);
    assign head    = mem[rd_ptr_q];
    // Isolates the lowest set bit: the lowest-index pending channel wins arbitration.
    assign push_oh = pending_q & (~pending_q + NUM_CH'(1));

    always_comb begin
        push_valid = 1'b0;
        push_ch    = 3'd0;
        push_ts    = 32'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                push_valid = 1'b1;
                push_ch    = 3'(i);
                push_ts    = cap_q[i];
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        cap_d     = cap_q;
        ovf_set   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (detect[i]) begin
                if (pending_q[i]) begin
                    ovf_set = 1'b1;
                end else begin
                    pending_d[i] = 1'b1;
                    cap_d[i]     = timer;
                end
            end
        end
        if (push) begin
            pending_d = pending_d & ~push_oh;
        end
    end

    always_comb begin
        ovf_d    = ovf_q;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        if (ctrl_wr) begin
            en_d     = avs_writedata[7:0];
            irq_en_d = avs_writedata[8];
            if (avs_writedata[31]) begin
                ovf_d = 1'b0;
            end
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (avs_read) begin
            case (avs_address)
                2'd0:    rdata_d = {7'd0, 9'(count_q), 13'd0, ovf_q, full, empty};
                2'd1:    rdata_d = empty ? 32'd0 : head[31:0];
                2'd2:    rdata_d = empty ? 32'd0 : {29'd0, head[34:32]};
                default: rdata_d = {23'd0, irq_en_q, en_q};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
            pending_q <= '0;
            cap_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            en_q      <= 8'hFF;
            irq_en_q  <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            sync1_q   <= event_in;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            pending_q <= pending_d;
            cap_q     <= cap_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            rdata_q   <= rdata_d;
        end
    end

    // Storage needs no reset: count/pointers gate every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {push_ch, push_ts};
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = irq_en_q && !empty;

endmodule

// File: tb/tb_timestamp_capture.sv
// tb/tb_timestamp_capture.sv - directed self-checking bench for timestamp_capture
module tb_timestamp_capture;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] timer;
    logic [3:0]  event_in = '0;
    logic [1:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        irq;

    logic [31:0] tcnt = 32'd0;
    logic [31:0] timer_off = 32'd100;
    int          vectors = 0;
    int          miscompares = 0;

    timestamp_capture #(.NUM_CH(4), .FIFO_DEPTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .timer        (timer),
        .event_in     (event_in),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata (avs_readdata),
        .irq          (irq)
    );

    always #5 clk = ~clk;
    // Timer advances on the falling edge so it is stable around each rising edge.
    always @(negedge clk) tcnt = tcnt + 32'd1;
    assign timer = timer_off + tcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        avs_address = a;
        avs_read    = 1'b1;
        @(posedge clk); #1;
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        @(posedge clk); #1;
        avs_address   = a;
        avs_writedata = v;
        avs_write     = 1'b1;
        @(posedge clk); #1;
        avs_write = 1'b0;
    endtask

    // Raises the mask, returns the timer seen at that moment; capture lands on t+3.
    task automatic pulse(input logic [3:0] m, output logic [31:0] t);
        @(posedge clk); #1;
        t = timer;
        event_in = m;
        repeat (3) @(posedge clk);
        #1;
        event_in = '0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] d, t, t3;
        logic [31:0] ts [17];

        do_reset();
        chk("reset_readdata", avs_readdata, 32'h0);
        chk("reset_irq", {31'd0, irq}, 32'h0);
        rd(2'd0, d); chk("reset_status", d, 32'h0000_0001);
        rd(2'd3, d); chk("reset_ctrl", d, 32'h0000_00FF);

        wr(2'd3, 32'h0000_01FF);
        pulse(4'b0010, t);
        chk("single_irq_on", {31'd0, irq}, 32'h1);
        rd(2'd0, d); chk("single_status", d, 32'h0001_0000);
        rd(2'd2, d); chk("single_headch", d, 32'h1);
        rd(2'd1, d); chk("single_tstamp", d, t + 32'd3);
        rd(2'd0, d); chk("single_empty", d, 32'h0000_0001);
        chk("single_irq_off", {31'd0, irq}, 32'h0);

        pulse(4'b0101, t);
        rd(2'd0, d); chk("simul_status", d, 32'h0002_0000);
        rd(2'd2, d); chk("simul_ch_a", d, 32'h0);
        rd(2'd1, d); chk("simul_ts_a", d, t + 32'd3);
        rd(2'd2, d); chk("simul_ch_b", d, 32'h2);
        rd(2'd1, d); chk("simul_ts_b", d, t + 32'd3);
        rd(2'd0, d); chk("simul_empty", d, 32'h0000_0001);

        timer_off = 32'hFFFF_FFFE - tcnt;
        pulse(4'b0010, t);
        rd(2'd1, d); chk("wrap_tstamp", d, 32'h0000_0002);

        rd(2'd1, d); chk("empty_tstamp", d, 32'h0);
        rd(2'd0, d); chk("empty_status", d, 32'h0000_0001);
        repeat (3) @(posedge clk);
        #1;
        chk("readdata_hold", avs_readdata, 32'h0000_0001);
        wr(2'd3, 32'h0000_01FE);
        pulse(4'b0001, t);
        rd(2'd0, d); chk("masked_status", d, 32'h0000_0001);
        wr(2'd3, 32'h0000_01FF);

        for (int i = 0; i < 17; i++) begin
            pulse(4'b0001, t);
            ts[i] = t + 32'd3;
        end
        rd(2'd0, d); chk("full_status", d, 32'h0010_0002);
        rd(2'd1, d); chk("full_pop0", d, ts[0]);
        rd(2'd0, d); chk("full_refill", d, 32'h0010_0002);
        for (int i = 1; i < 17; i++) begin
            rd(2'd1, d); chk($sformatf("full_pop%0d", i), d, ts[i]);
        end
        rd(2'd0, d); chk("full_drained", d, 32'h0000_0001);

        for (int i = 0; i < 16; i++) pulse(4'b0001, t);
        pulse(4'b1000, t3);
        pulse(4'b1000, t);
        rd(2'd0, d); chk("ovf_status", d, 32'h0010_0006);
        wr(2'd3, 32'h8000_01FF);
        rd(2'd0, d); chk("ovf_cleared", d, 32'h0010_0002);
        rd(2'd3, d); chk("ctrl_read", d, 32'h0000_01FF);
        for (int i = 0; i < 16; i++) rd(2'd1, d);
        rd(2'd0, d); chk("ovf_one_left", d, 32'h0001_0000);
        rd(2'd2, d); chk("ovf_headch", d, 32'h3);
        rd(2'd1, d); chk("ovf_tstamp", d, t3 + 32'd3);
        rd(2'd0, d); chk("ovf_empty", d, 32'h0000_0001);

        for (int i = 0; i < 5; i++) pulse(4'b0001, t);
        rd(2'd0, d); chk("mid_status", d, 32'h0005_0000);
        chk("mid_irq", {31'd0, irq}, 32'h1);
        do_reset();
        chk("rst2_irq", {31'd0, irq}, 32'h0);
        chk("rst2_readdata", avs_readdata, 32'h0);
        rd(2'd0, d); chk("rst2_status", d, 32'h0000_0001);
        rd(2'd3, d); chk("rst2_ctrl", d, 32'h0000_00FF);
        pulse(4'b0100, t);
        rd(2'd0, d); chk("post_rst_status", d, 32'h0001_0000);
        rd(2'd2, d); chk("post_rst_headch", d, 32'h2);
        chk("post_rst_irq", {31'd0, irq}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
